// File: rtl/serial_cmpr_ctrl_if.sv
// Handshake/bus bundle between the word-compare sequencer and its surroundings.
// Latency: none (wires only).
// Backpressure: bit_valid from upstream stalls the scan; no downstream backpressure.
//
// Signals:
//   start                       request a new comparison
//   bit_valid                   slice triple valid for bit_idx this cycle
//   alessb, aequalb, agreaterb  1-bit slice results for the current bit pair
//   bit_idx                     bit position requested from the upstream mux
//   busy, done                  scan in progress / one-cycle completion pulse
//   lt, eq, gt, err             held word-compare result and one-hot error flag
interface serial_cmpr_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int IDXW = $clog2(WIDTH);

    logic            start;
    logic            bit_valid;
    logic            alessb;
    logic            aequalb;
    logic            agreaterb;
    logic [IDXW-1:0] bit_idx;
    logic            busy;
    logic            done;
    logic            lt;
    logic            eq;
    logic            gt;
    logic            err;

    // Requester / slice side
    modport master (
        output start, bit_valid, alessb, aequalb, agreaterb,
        input  bit_idx, busy, done, lt, eq, gt, err
    );

    // Sequencer side
    modport slave (
        input  start, bit_valid, alessb, aequalb, agreaterb,
        output bit_idx, busy, done, lt, eq, gt, err
    );
endinterface

// File: rtl/serial_cmpr_ctrl.sv
// Sequences a 1-bit comparator slice MSB-first to produce a WIDTH-bit lt/eq/gt result.
// Latency: WIDTH cycles from start acceptance (WIDTH-k on early exit at bit k), +1 per stall.
// Backpressure: bit_valid low freezes the scan; start is only accepted in IDLE or DONE.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  serial_cmpr_ctrl_if.slave (start/bit_valid/slice triple in; bit_idx/busy/done/lt/eq/gt/err out)
module serial_cmpr_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    serial_cmpr_ctrl_if.slave  bus
);
    localparam int              IDXW    = $clog2(WIDTH);
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] bit_idx_q, bit_idx_d;
    logic            lt_q, lt_d;
    logic            eq_q, eq_d;
    logic            gt_q, gt_d;
    logic            err_q, err_d;
    logic            decided_q, decided_d;

    logic            onehot;
    logic            load_start;
    logic            early_stop;

    // Exactly one of the three slice outputs may be high for a sane bit pair.
    assign onehot = (bus.alessb & ~bus.aequalb & ~bus.agreaterb) |
                    (~bus.alessb & bus.aequalb & ~bus.agreaterb) |
                    (~bus.alessb & ~bus.aequalb & bus.agreaterb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_idx_q <= IDX_TOP;
            lt_q      <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            err_q     <= 1'b0;
            decided_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            lt_q      <= lt_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
            err_q     <= err_d;
            decided_q <= decided_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        lt_d       = lt_q;
        eq_d       = eq_q;
        gt_d       = gt_q;
        err_d      = err_q;
        decided_d  = decided_q;
        load_start = 1'b0;
        early_stop = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load_start = 1'b1;
                end
            end

            S_SCAN: begin
                if (bus.bit_valid) begin
                    if (!onehot) begin
                        // A corrupt slice invalidates any earlier decision.
                        err_d   = 1'b1;
                        lt_d    = 1'b0;
                        eq_d    = 1'b0;
                        gt_d    = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        // Only the first (most significant) difference decides.
                        if ((bus.agreaterb | bus.alessb) && !decided_q) begin
                            gt_d       = bus.agreaterb;
                            lt_d       = bus.alessb;
                            decided_d  = 1'b1;
                            early_stop = EARLY_EXIT;
                        end

                        // On early exit bit_idx stays at the deciding bit.
                        if (early_stop) begin
                            state_d = S_DONE;
                        end else if (bit_idx_q == '0) begin
                            state_d = S_DONE;
                            if (!decided_d) begin
                                eq_d = 1'b1;
                            end
                        end else begin
                            bit_idx_d = bit_idx_q - 1'b1;
                        end
                    end
                end
            end

            S_DONE: begin
                if (bus.start) begin
                    load_start = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results from the previous comparison are held until a start is taken.
        if (load_start) begin
            state_d   = S_SCAN;
            bit_idx_d = IDX_TOP;
            lt_d      = 1'b0;
            eq_d      = 1'b0;
            gt_d      = 1'b0;
            err_d     = 1'b0;
            decided_d = 1'b0;
        end
    end

    // All outputs come straight from state registers.
    assign bus.bit_idx = bit_idx_q;
    assign bus.busy    = (state_q == S_SCAN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.lt      = lt_q;
    assign bus.eq      = eq_q;
    assign bus.gt      = gt_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_serial_cmpr_ctrl.sv
// Directed bench for serial_cmpr_ctrl: one early-exit instance and one full-scan instance.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: bit_valid dropped for a stall window; start pulsed in SCAN and DONE.
module tb_serial_cmpr_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_e = 1'b0;
    logic       start_n = 1'b0;
    logic       bit_valid = 1'b1;
    logic       bad = 1'b0;
    logic [7:0] a_w = 8'h00;
    logic [7:0] b_w = 8'h00;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    serial_cmpr_ctrl_if #(.WIDTH(8)) if_e ();
    serial_cmpr_ctrl_if #(.WIDTH(8)) if_n ();

    // Behavioural slice + mux: bit pair selected by each DUT's own bit_idx.
    assign if_e.start     = start_e;
    assign if_e.bit_valid = bit_valid;
    assign if_e.alessb    = bad ? 1'b1 : (~a_w[if_e.bit_idx] &  b_w[if_e.bit_idx]);
    assign if_e.aequalb   = bad ? 1'b1 : ( a_w[if_e.bit_idx] ~^ b_w[if_e.bit_idx]);
    assign if_e.agreaterb = bad ? 1'b0 : ( a_w[if_e.bit_idx] & ~b_w[if_e.bit_idx]);

    assign if_n.start     = start_n;
    assign if_n.bit_valid = bit_valid;
    assign if_n.alessb    = bad ? 1'b1 : (~a_w[if_n.bit_idx] &  b_w[if_n.bit_idx]);
    assign if_n.aequalb   = bad ? 1'b1 : ( a_w[if_n.bit_idx] ~^ b_w[if_n.bit_idx]);
    assign if_n.agreaterb = bad ? 1'b0 : ( a_w[if_n.bit_idx] & ~b_w[if_n.bit_idx]);

    serial_cmpr_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e (
        .clk (clk),
        .rst (rst),
        .bus (if_e)
    );

    serial_cmpr_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (if_n)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts edges until the selected instance shows done (bounded at 40).
    task automatic wait_done(input bit sel_n, output int cnt);
        cnt = 0;
        do begin
            cycle();
            cnt++;
        end while (((sel_n ? if_n.done : if_e.done) !== 1'b1) && cnt < 40);
    endtask

    initial begin
        // ---------------- reset state ----------------
        cycle();
        chk("rst_idx",  32'(if_e.bit_idx), 32'd7);
        chk("rst_busy", 32'(if_e.busy), 32'd0);
        chk("rst_done", 32'(if_e.done), 32'd0);
        chk("rst_res",  32'({if_e.lt, if_e.eq, if_e.gt, if_e.err}), 32'd0);
        chk("rst_idx_n", 32'(if_n.bit_idx), 32'd7);
        rst = 1'b0;
        cycle();
        chk("idle_busy", 32'(if_e.busy), 32'd0);

        // ---------------- equal words 0xA5 ----------------
        a_w = 8'hA5; b_w = 8'hA5;
        start_e = 1'b1; start_n = 1'b1;
        cycle();
        start_e = 1'b0; start_n = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            chk("eq_idx",  32'(if_e.bit_idx), 32'(k));
            chk("eq_busy", 32'(if_e.busy), 32'd1);
            cycle();
        end
        chk("eq_done",   32'(if_e.done), 32'd1);
        chk("eq_busy0",  32'(if_e.busy), 32'd0);
        chk("eq_res",    32'({if_e.lt, if_e.eq, if_e.gt, if_e.err}), 32'b0100);
        chk("eq_done_n", 32'(if_n.done), 32'd1);
        chk("eq_res_n",  32'({if_n.lt, if_n.eq, if_n.gt, if_n.err}), 32'b0100);
        cycle();
        chk("eq_pulse",  32'(if_e.done), 32'd0);
        chk("eq_hold",   32'(if_e.eq), 32'd1);

        // ---------------- early exit 0x80 vs 0x7F ----------------
        a_w = 8'h80; b_w = 8'h7F;
        start_e = 1'b1;
        cycle();
        start_e = 1'b0;
        wait_done(1'b0, n);
        chk("ee_lat", 32'(n), 32'd1);
        chk("ee_res", 32'({if_e.lt, if_e.eq, if_e.gt, if_e.err}), 32'b0010);
        chk("ee_idx", 32'(if_e.bit_idx), 32'd7);
        cycle();
        chk("ee_idle_idx", 32'(if_e.bit_idx), 32'd7);

        // ---------------- full scan 0x40 vs 0x3F ----------------
        a_w = 8'h40; b_w = 8'h3F;
        start_n = 1'b1;
        cycle();
        start_n = 1'b0;
        wait_done(1'b1, n);
        chk("fs_gt_lat", 32'(n), 32'd8);
        chk("fs_gt_res", 32'({if_n.lt, if_n.eq, if_n.gt, if_n.err}), 32'b0010);
        chk("fs_gt_idx", 32'(if_n.bit_idx), 32'd0);
        cycle();

        // ---------------- 0x3C vs 0x3D, both instances ----------------
        a_w = 8'h3C; b_w = 8'h3D;
        start_e = 1'b1; start_n = 1'b1;
        cycle();
        start_e = 1'b0; start_n = 1'b0;
        wait_done(1'b0, n);
        chk("lt_lat_e", 32'(n), 32'd8);
        chk("lt_res_e", 32'({if_e.lt, if_e.eq, if_e.gt, if_e.err}), 32'b1000);
        chk("lt_done_n", 32'(if_n.done), 32'd1);
        chk("lt_res_n", 32'({if_n.lt, if_n.eq, if_n.gt, if_n.err}), 32'b1000);
        cycle();

        // ---------------- stall at bit 4, 0x0F vs 0x0F ----------------
        a_w = 8'h0F; b_w = 8'h0F;
        start_e = 1'b1;
        cycle();
        start_e = 1'b0;
        cycle(); cycle(); cycle();
        chk("st_idx_pre", 32'(if_e.bit_idx), 32'd4);
        bit_valid = 1'b0;
        cycle(); cycle(); cycle();
        chk("st_idx_hold", 32'(if_e.bit_idx), 32'd4);
        chk("st_busy",     32'(if_e.busy), 32'd1);
        bit_valid = 1'b1;
        wait_done(1'b0, n);
        chk("st_lat", 32'(n + 6), 32'd11);
        chk("st_res", 32'({if_e.lt, if_e.eq, if_e.gt, if_e.err}), 32'b0100);
        cycle();

        // ---------------- bad slice at bit 5 ----------------
        a_w = 8'hFF; b_w = 8'hFF;
        start_e = 1'b1;
        cycle();
        start_e = 1'b0;
        cycle(); cycle();
        chk("bad_idx", 32'(if_e.bit_idx), 32'd5);
        bad = 1'b1;
        cycle();
        bad = 1'b0;
        chk("bad_done", 32'(if_e.done), 32'd1);
        chk("bad_res",  32'({if_e.lt, if_e.eq, if_e.gt, if_e.err}), 32'b0001);
        cycle();
        chk("bad_hold", 32'(if_e.err), 32'd1);

        // ---------------- start during SCAN is ignored ----------------
        a_w = 8'h00; b_w = 8'h00;
        start_e = 1'b1;
        cycle();
        start_e = 1'b0;
        cycle();
        start_e = 1'b1;
        cycle();
        start_e = 1'b0;
        chk("scan_start_idx", 32'(if_e.bit_idx), 32'd5);
        wait_done(1'b0, n);
        chk("scan_start_lat", 32'(n), 32'd6);

        // ---------------- start in DONE cycle ----------------
        start_e = 1'b1;
        cycle();
        start_e = 1'b0;
        chk("b2b_busy", 32'(if_e.busy), 32'd1);
        chk("b2b_idx",  32'(if_e.bit_idx), 32'd7);
        chk("b2b_done", 32'(if_e.done), 32'd0);
        chk("b2b_clr",  32'(if_e.eq), 32'd0);
        wait_done(1'b0, n);
        chk("b2b_lat", 32'(n), 32'd8);
        cycle();

        // ---------------- reset mid-scan at bit 3 ----------------
        a_w = 8'h55; b_w = 8'h55;
        start_e = 1'b1;
        cycle();
        start_e = 1'b0;
        cycle(); cycle(); cycle(); cycle();
        chk("mrst_pre_idx", 32'(if_e.bit_idx), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_idx",  32'(if_e.bit_idx), 32'd7);
        chk("mrst_busy", 32'(if_e.busy), 32'd0);
        chk("mrst_res",  32'({if_e.done, if_e.lt, if_e.eq, if_e.gt, if_e.err}), 32'd0);
        #2;
        rst = 1'b0;
        cycle();
        chk("mrst_idle_busy", 32'(if_e.busy), 32'd0);
        chk("mrst_idle_idx",  32'(if_e.bit_idx), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
